seven_seg_scan_2digit: RTL and testbench

//   Consumer end of the 2-digit BCD counter interface (ones/tens nibbles).

---
 rtl/seven_seg_scan_2digit.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan_2digit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_2digit.sv
// Two-digit multiplexed 7-segment driver: samples {tens,ones} once per scan,
// blanks anodes at each slot start, and optionally suppresses a leading zero.
//
// state  | meaning
// S_ONES | ones digit slot, an[0] may be lit
// S_TENS | tens digit slot, an[1] may be lit
module seven_seg_scan_2digit #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 1,
   parameter int ACTIVE_LOW  = 1,
   parameter int LZ_BLANK    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   input  logic       err_clr,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       bcd_err
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_N  = CNT_W'(BLANK_CYC);
   localparam logic [6:0]       SEG_DARK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0]       AN_DARK  = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   typedef enum logic {
      S_ONES = 1'b0,
      S_TENS = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       r_shadow;
   logic [6:0]       r_seg;
   logic [1:0]       r_an;
   logic             r_bcd_err;
   logic             w_sample;
   logic             w_dark;
   logic [3:0]       w_digit;
   logic [6:0]       w_seg_hi;
   logic [1:0]       w_an_hi;
   logic [6:0]       w_seg_nxt;
   logic [1:0]       w_an_nxt;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_ONES;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      if (r_cnt == CNT_MAX) begin
         w_cnt_nxt   = '0;
         w_state_nxt = (r_state == S_ONES) ? S_TENS : S_ONES;
      end
   end

   // Outputs are computed from the shadow, never the live inputs, so a digit
   // changing mid-scan cannot tear the displayed value.
   always_comb begin
      w_digit  = (r_state == S_TENS) ? r_shadow[7:4] : r_shadow[3:0];
      w_dark   = (r_cnt < BLANK_N) ||
                 ((LZ_BLANK != 0) && (r_state == S_TENS) && (r_shadow[7:4] == 4'd0));
      w_seg_hi = '0;
      w_an_hi  = '0;
      if (!w_dark) begin
         w_seg_hi = f_decode(w_digit);
         w_an_hi  = (r_state == S_TENS) ? 2'b10 : 2'b01;
      end
      w_seg_nxt = (ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
      w_an_nxt  = (ACTIVE_LOW != 0) ? ~w_an_hi  : w_an_hi;
   end

   assign w_sample = (r_state == S_ONES) && (r_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow  <= 8'h00;
         r_seg     <= SEG_DARK;
         r_an      <= AN_DARK;
         r_bcd_err <= 1'b0;
      end else begin
         r_seg <= w_seg_nxt;
         r_an  <= w_an_nxt;
         if (w_sample) begin
            r_shadow <= {tens, ones};
         end
         if (w_sample && ((tens > 4'd9) || (ones > 4'd9))) begin
            r_bcd_err <= 1'b1;
         end else if (err_clr) begin
            r_bcd_err <= 1'b0;
         end
      end
   end

   assign seg     = r_seg;
   assign an      = r_an;
   assign bcd_err = r_bcd_err;

endmodule

// File: tb/tb_seven_seg_scan_2digit.sv
// Self-checking bench for seven_seg_scan_2digit (REFRESH_DIV=4, BLANK_CYC=1,
// ACTIVE_LOW=1, LZ_BLANK=1) against directed patterns and a cycle-count model.
module tb_seven_seg_scan_2digit;

   localparam int R     = 4;
   localparam int BLANK = 1;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic [3:0] ones    = 4'd0;
   logic [3:0] tens    = 4'd0;
   logic       err_clr = 1'b0;
   logic [6:0] seg;
   logic [1:0] an;
   logic       bcd_err;

   int total = 0;
   int bad   = 0;

   seven_seg_scan_2digit #(
      .REFRESH_DIV(R),
      .BLANK_CYC  (BLANK),
      .ACTIVE_LOW (1),
      .LZ_BLANK   (1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .ones   (ones),
      .tens   (tens),
      .err_clr(err_clr),
      .seg    (seg),
      .an     (an),
      .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_lut [16];

   // Reference model: position within the scan comes from the number of
   // edges since reset release; inputs only matter at the start of a scan.
   int         m_n;
   int         m_pos;
   int         m_slot;
   int         m_c;
   logic [3:0] m_dig;
   logic [7:0] m_shadow;
   logic [6:0] exp_seg;
   logic [1:0] exp_an;
   logic       exp_err;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_n      = 0;
         m_shadow = 8'h00;
         exp_seg  = 7'h7F;
         exp_an   = 2'b11;
         exp_err  = 1'b0;
      end else begin
         m_pos  = m_n % (2 * R);
         m_slot = m_pos / R;
         m_c    = m_pos % R;
         m_dig  = (m_slot == 1) ? m_shadow[7:4] : m_shadow[3:0];
         if (m_c < BLANK || (m_slot == 1 && m_shadow[7:4] == 4'd0)) begin
            exp_seg = 7'h7F;
            exp_an  = 2'b11;
         end else begin
            exp_seg = ~seg_lut[m_dig];
            exp_an  = (m_slot == 1) ? 2'b01 : 2'b10;
         end
         if (m_pos == 0 && (tens > 4'd9 || ones > 4'd9)) exp_err = 1'b1;
         else if (err_clr) exp_err = 1'b0;
         if (m_pos == 0) m_shadow = {tens, ones};
         m_n = m_n + 1;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      tens = 4'd4;
      ones = 4'hC;
      do_reset();
      repeat (6) @(negedge clk);
      total++;
      if (bcd_err !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_err bcd_err=%b want=1", bcd_err);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if (an !== 2'b11 || seg !== 7'h7F || bcd_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_async an=%b seg=%h err=%b want 11/7f/0", an, seg, bcd_err);
      end
      @(negedge clk);
      ones  = 4'd7;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (an !== 2'b11 || seg !== 7'h7F) begin
         bad++;
         $display("FAIL reset_release_blank an=%b seg=%h want 11/7f", an, seg);
      end
      @(negedge clk);
      total++;
      if (an !== 2'b10 || seg !== 7'h78) begin
         bad++;
         $display("FAIL reset_first_lit an=%b seg=%h want 10/78", an, seg);
      end
   endtask

   task automatic test_pattern_47();
      logic [1:0] e_an;
      logic [6:0] e_seg;
      int         p;
      tens = 4'd4;
      ones = 4'd7;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         p = (k - 1) % 8;
         if (p == 0 || p == 4) begin e_an = 2'b11; e_seg = 7'h7F; end
         else if (p < 4)       begin e_an = 2'b10; e_seg = 7'h78; end
         else                  begin e_an = 2'b01; e_seg = 7'h19; end
         total++;
         if (an !== e_an || seg !== e_seg) begin
            bad++;
            $display("FAIL pattern47 k=%0d an=%b seg=%h want %b/%h", k, an, seg, e_an, e_seg);
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [1:0] e_an;
      logic [6:0] e_seg;
      int         p;
      tens = 4'd0;
      ones = 4'd5;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         p = (k - 1) % 8;
         if (p >= 1 && p <= 3) begin e_an = 2'b10; e_seg = 7'h12; end
         else                  begin e_an = 2'b11; e_seg = 7'h7F; end
         total++;
         if (an !== e_an || seg !== e_seg) begin
            bad++;
            $display("FAIL lz_blank k=%0d an=%b seg=%h want %b/%h", k, an, seg, e_an, e_seg);
         end
      end
   endtask

   task automatic test_no_tearing();
      logic [1:0] e_an;
      logic [6:0] e_seg;
      int         p;
      tens = 4'd4;
      ones = 4'd7;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         p = (k - 1) % 8;
         if (p == 0 || p == 4) begin e_an = 2'b11; e_seg = 7'h7F; end
         else if (p < 4)       begin e_an = 2'b10; e_seg = 7'h78; end
         else                  begin e_an = 2'b01; e_seg = (k <= 8) ? 7'h19 : 7'h00; end
         total++;
         if (an !== e_an || seg !== e_seg) begin
            bad++;
            $display("FAIL no_tearing k=%0d an=%b seg=%h want %b/%h", k, an, seg, e_an, e_seg);
         end
         if (k == 5) tens = 4'd8;
      end
   endtask

   task automatic test_bcd_err();
      tens = 4'd1;
      ones = 4'hC;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k >= 2 && k <= 4) begin
            total++;
            if (an !== 2'b10 || seg !== 7'h3F) begin
               bad++;
               $display("FAIL bcd_dash k=%0d an=%b seg=%h want 10/3f", k, an, seg);
            end
         end
         if (k == 1 || k == 5 || k == 9 || k == 12) begin
            total++;
            if (bcd_err !== 1'b1) begin
               bad++;
               $display("FAIL bcd_err_set k=%0d bcd_err=%b want 1", k, bcd_err);
            end
         end
         if (k == 6) begin
            total++;
            if (bcd_err !== 1'b0) begin
               bad++;
               $display("FAIL bcd_err_clr k=%0d bcd_err=%b want 0", k, bcd_err);
            end
         end
         case (k)
            5: begin err_clr = 1'b1; ones = 4'd7; end
            6: begin err_clr = 1'b0; ones = 4'hC; end
            8: err_clr = 1'b1;
            9: err_clr = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_counter_wrap();
      int         v;
      logic [1:0] e_an;
      logic [6:0] e_seg;
      v    = 98;
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      do_reset();
      for (int s = 0; s < 4; s++) begin
         for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            if (p == 0 || p == 4) begin e_an = 2'b11; e_seg = 7'h7F; end
            else if (p < 4) begin e_an = 2'b10; e_seg = ~seg_lut[v % 10]; end
            else if (v / 10 == 0) begin e_an = 2'b11; e_seg = 7'h7F; end
            else begin e_an = 2'b01; e_seg = ~seg_lut[v / 10]; end
            total++;
            if (an !== e_an || seg !== e_seg) begin
               bad++;
               $display("FAIL counter_wrap v=%0d p=%0d an=%b seg=%h want %b/%h",
                        v, p, an, seg, e_an, e_seg);
            end
            if (p == 7) begin
               v    = (v + 1) % 100;
               tens = 4'(v / 10);
               ones = 4'(v % 10);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 240; k++) begin
         @(negedge clk);
         total++;
         if (an !== exp_an || seg !== exp_seg || bcd_err !== exp_err) begin
            bad++;
            $display("FAIL random k=%0d an=%b/%b seg=%h/%h err=%b/%b",
                     k, an, exp_an, seg, exp_seg, bcd_err, exp_err);
         end
         if ($urandom_range(0, 2) == 0) begin
            ones = 4'($urandom_range(0, 15));
            tens = 4'($urandom_range(0, 15));
         end
         err_clr = ($urandom_range(0, 3) == 0);
         if (k == 100 || k == 171) begin
            #($urandom_range(1, 4));
            reset = 1'b0;
            #1;
            total++;
            if (an !== 2'b11 || seg !== 7'h7F || bcd_err !== 1'b0) begin
               bad++;
               $display("FAIL random_reset k=%0d an=%b seg=%h err=%b want 11/7f/0",
                        k, an, seg, bcd_err);
            end
            @(negedge clk);
            reset = 1'b1;
         end
      end
      err_clr = 1'b0;
   endtask

   initial begin
      seg_lut[0]  = 7'h3F; seg_lut[1]  = 7'h06; seg_lut[2]  = 7'h5B; seg_lut[3]  = 7'h4F;
      seg_lut[4]  = 7'h66; seg_lut[5]  = 7'h6D; seg_lut[6]  = 7'h7D; seg_lut[7]  = 7'h07;
      seg_lut[8]  = 7'h7F; seg_lut[9]  = 7'h6F;
      for (int i = 10; i < 16; i++) seg_lut[i] = 7'h40;
      test_reset();
      test_pattern_47();
      test_lz_blank();
      test_no_tearing();
      test_bcd_err();
      test_counter_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
